crc_append_tx: RTL

//  Parametrised CRC append stage on the switch write path: passes packet beats

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc_par_step.sv | 26 ++
 rtl/crc_append_tx.sv | 120 ++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the CRC append path: FSM state encoding and common
// generator polynomials (implicit top term omitted).
package crc_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StBody,
      StCrcPend
   } crcTxState_e;

   localparam logic [15:0] CRC16_CCITT = 16'h1021;
   localparam logic [7:0]  CRC8_SMBUS  = 8'h07;
   localparam logic [31:0] CRC32       = 32'h04C11DB7;

endpackage

// File: rtl/crc_par_step.sv
// Combinational DATA_W-bit parallel CRC update, data consumed MSB first,
// no reflection.
module crc_par_step #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CRC_W  = 16
) (
   input  logic [CRC_W-1:0]  crcIn,
   input  logic [DATA_W-1:0] data,
   input  logic [CRC_W-1:0]  poly,
   output logic [CRC_W-1:0]  crcOut
);

   logic [CRC_W-1:0] c;
   logic             fb;

   always_comb begin
      c  = crcIn;
      fb = 1'b0;
      for (int i = DATA_W - 1; i >= 0; i--) begin
         fb = c[CRC_W-1] ^ data[i];
         c  = {c[CRC_W-2:0], 1'b0} ^ ({CRC_W{fb}} & poly);
      end
      crcOut = c;
   end

endmodule

// File: rtl/crc_append_tx.sv
// CRC append stage: forwards packet beats to the unpack FIFO and appends one CRC beat
// per packet. Define CRCTX_PKT_CNT_EN to add the oPktCnt/oErrCnt counters.
module crc_append_tx
   import crc_pkg::*;
#(
   parameter int unsigned      DATA_W     = 32,
   parameter int unsigned      CRC_W      = 16,
   parameter logic [CRC_W-1:0] CRC_POLY   = CRC16_CCITT,
   parameter logic [CRC_W-1:0] CRC_INIT   = 16'hFFFF,
   parameter logic [CRC_W-1:0] CRC_XOROUT = 16'h0000,
   parameter int unsigned      HDR_WORDS  = 1
) (
   input  logic              iClk,
   input  logic              iRst_n,
   input  logic              iWrSop,
   input  logic              iWrEop,
   input  logic              iWrVld,
   input  logic [DATA_W-1:0] iWrData,
   output logic              oFull,
   output logic              oWrSop,
   output logic              oWrEop,
   output logic              oWrVld,
   output logic [DATA_W-1:0] oWrData,
   input  logic              iFifoFull,
   input  logic              iAlmostFull,
   output logic              oProtoErr
`ifdef CRCTX_PKT_CNT_EN
   ,
   output logic [31:0]       oPktCnt,
   output logic [15:0]       oErrCnt
`endif
);

   crcTxState_e      stateQ;
   logic [CRC_W-1:0] crcQ, crcBase, crcStep, crcNext;
   logic [3:0]       hdrCntQ, beatHdrCnt, hdrCntNext;
   logic             accept, outFree, fold, loadBeat;

   assign oFull    = iFifoFull | (stateQ == StCrcPend) | ((stateQ == StIdle) & iAlmostFull);
   assign accept   = iWrVld & ~oFull;
   assign outFree  = ~oWrVld | ~iFifoFull;
   assign loadBeat = accept & (iWrSop | (stateQ == StBody));

   // A sop beat always restarts the CRC and header count, even mid-packet.
   always_comb begin
      beatHdrCnt = iWrSop ? 4'd0 : hdrCntQ;
      crcBase    = iWrSop ? CRC_INIT : crcQ;
      fold       = {1'b0, beatHdrCnt} >= 5'(HDR_WORDS);
      crcNext    = fold ? crcStep : crcBase;
      hdrCntNext = fold ? beatHdrCnt : beatHdrCnt + 4'd1;
   end

   crc_par_step #(
      .DATA_W(DATA_W),
      .CRC_W (CRC_W)
   ) uStep (
      .crcIn (crcBase),
      .data  (iWrData),
      .poly  (CRC_POLY),
      .crcOut(crcStep)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         stateQ    <= StIdle;
         crcQ      <= CRC_INIT;
         hdrCntQ   <= 4'd0;
         oWrSop    <= 1'b0;
         oWrEop    <= 1'b0;
         oWrVld    <= 1'b0;
         oWrData   <= '0;
         oProtoErr <= 1'b0;
      end else begin
         oProtoErr <= 1'b0;
         if (oWrVld && !iFifoFull) oWrVld <= 1'b0;
         case (stateQ)
            StIdle, StBody: begin
               // oFull covers iFifoFull, so an accepted beat always finds the output free.
               if (loadBeat) begin
                  oWrVld  <= 1'b1;
                  oWrSop  <= iWrSop;
                  oWrEop  <= 1'b0;
                  oWrData <= iWrData;
                  crcQ    <= crcNext;
                  hdrCntQ <= hdrCntNext;
                  stateQ  <= iWrEop ? StCrcPend : StBody;
               end
               oProtoErr <= accept & ((stateQ == StBody) ? iWrSop : ~iWrSop);
            end
            StCrcPend: begin
               if (outFree) begin
                  oWrVld  <= 1'b1;
                  oWrSop  <= 1'b0;
                  oWrEop  <= 1'b1;
                  oWrData <= DATA_W'(crcQ ^ CRC_XOROUT);
                  crcQ    <= CRC_INIT;
                  hdrCntQ <= 4'd0;
                  stateQ  <= StIdle;
               end
            end
            default: stateQ <= StIdle;
         endcase
      end
   end

`ifdef CRCTX_PKT_CNT_EN
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oPktCnt <= '0;
         oErrCnt <= '0;
      end else begin
         if (oWrVld && oWrEop && !iFifoFull) oPktCnt <= oPktCnt + 32'd1;
         if (oProtoErr) oErrCnt <= oErrCnt + 16'd1;
      end
   end
`else
   // Counters compiled out; the datapath is identical either way.
`endif

endmodule
